// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the MEM-stage core port and the debug/loader port.
// Issues in IDLE with combinational arbitration and sequences multi-cycle reads in BUSY.
`timescale 1ns/1ps
module dmem_arbiter #(
  parameter int ADDR_W       = 10,
  parameter int MEM_LAT      = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [3:0]        core_be,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [31:0]       core_wdata,
  output logic [31:0]       core_rdata,
  output logic              core_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [31:0]       dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [31:0]       dbg_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [2:0] LAT_LOAD = 3'(MEM_LAT);
  localparam logic [3:0] STREAK_MAX = 4'(STARVE_LIMIT);

  state_t      state;
  logic [2:0]  cnt;
  logic [3:0]  streak;
  logic        owner_dbg;
  logic [31:0] core_rdata_q;
  logic [31:0] dbg_rdata_q;

  logic dbg_wins, issue_core, issue_dbg, resp, resp_core, resp_dbg;

  // Outputs are gated by rst_n so they read 0 for the whole reset window,
  // not just after the first edge.
  always_comb begin
    dbg_wins   = dbg_req && (!core_req || streak == STREAK_MAX);
    issue_core = rst_n && state == IDLE && core_req && !dbg_wins;
    issue_dbg  = rst_n && state == IDLE && dbg_wins;
    resp       = rst_n && state == BUSY && cnt == 3'd1;
    resp_core  = resp && !owner_dbg;
    resp_dbg   = resp && owner_dbg;

    mem_en    = issue_core || issue_dbg;
    mem_we    = '0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (issue_core) begin
      mem_we    = core_we;
      mem_be    = core_we ? core_be : 4'hF;
      mem_addr  = core_addr;
      mem_wdata = core_wdata;
    end else if (issue_dbg) begin
      mem_we    = dbg_we;
      mem_be    = 4'hF;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
    end

    dbg_gnt    = issue_dbg;
    dbg_rvalid = resp_dbg;
    core_rdata = resp_core ? mem_rdata : core_rdata_q;
    dbg_rdata  = resp_dbg  ? mem_rdata : dbg_rdata_q;
    core_stall = rst_n && core_req && !(issue_core && core_we) && !resp_core;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      streak       <= '0;
      owner_dbg    <= 1'b0;
      core_rdata_q <= '0;
      dbg_rdata_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_en && !mem_we) begin
            state     <= BUSY;
            cnt       <= LAT_LOAD;
            owner_dbg <= issue_dbg;
          end
        end
        BUSY: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (resp_core) core_rdata_q <= mem_rdata;
      if (resp_dbg)  dbg_rdata_q  <= mem_rdata;

      if (!dbg_req || issue_dbg)
        streak <= '0;
      else if (issue_core && streak != STREAK_MAX)
        streak <= streak + 4'd1;
    end
  end

endmodule
